pixel_frame_capture: RTL and testbench

PIXEL_FRAME_CAPTURE -- requirements
Module: pixel_frame_capture

---
 rtl/pixel_pkg.sv | 15 +
 rtl/pixel_fifo.sv | 71 +++++++
 rtl/pixel_frame_capture.sv | 158 +++++++++++++++
 tb/tb_pixel_frame_capture.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared defaults and FSM state type for the pixel capture block
package pixel_pkg;

    localparam int DEF_PIXEL_NUM_ROW = 7;
    localparam int DEF_PIXEL_NUM_COL = 16;
    localparam int DEF_SAMPLE_WIDTH  = 10;
    localparam int DEF_FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RST_LVL = 2'd1,
        SIG_LVL = 2'd2
    } capture_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO, power-of-two depth, push-on-full allowed when popping
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A pop in the same cycle frees the slot the push needs.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is gated so an empty FIFO presents zeros rather than stale data.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/pixel_frame_capture.sv
// rtl/pixel_frame_capture.sv - raster pixel capture with optional CDS subtraction into an output FIFO
module pixel_frame_capture
    import pixel_pkg::*;
#(
    parameter int PIXEL_NUM_ROW = DEF_PIXEL_NUM_ROW,
    parameter int PIXEL_NUM_COL = DEF_PIXEL_NUM_COL,
    parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int ROW_BITS      = $clog2(PIXEL_NUM_ROW),
    parameter int COL_BITS      = $clog2(PIXEL_NUM_COL)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    frame_start,
    input  logic                    abort,
    input  logic                    cds_en,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [SAMPLE_WIDTH-1:0] out_data,
    output logic [ROW_BITS-1:0]     out_row,
    output logic [COL_BITS-1:0]     out_col,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overflow
);

    localparam int ENTRY_W = SAMPLE_WIDTH + ROW_BITS + COL_BITS;
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(PIXEL_NUM_ROW - 1);
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(PIXEL_NUM_COL - 1);

    capture_state_t          state_q, state_d;
    logic                    cds_mode_q, cds_mode_d;
    logic [SAMPLE_WIDTH-1:0] rst_reg_q, rst_reg_d;
    logic [ROW_BITS-1:0]     row_q, row_d;
    logic [COL_BITS-1:0]     col_q, col_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overflow_q, overflow_d;

    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [SAMPLE_WIDTH-1:0] result;
    logic [SAMPLE_WIDTH-1:0] cds_diff;
    logic [ENTRY_W-1:0]      fifo_wdata;
    logic [ENTRY_W-1:0]      fifo_rdata;
    logic                    last_pixel;

    assign cds_diff   = rst_reg_q - sample_data;
    assign result     = !cds_mode_q ? sample_data
                      : ((sample_data > rst_reg_q) ? '0 : cds_diff);
    assign last_pixel = (row_q == LAST_ROW) && (col_q == LAST_COL);

    always_comb begin
        state_d      = state_q;
        cds_mode_d   = cds_mode_q;
        rst_reg_d    = rst_reg_q;
        row_d        = row_q;
        col_d        = col_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        push         = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            rst_reg_d = '0;
            row_d     = '0;
            col_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        cds_mode_d = cds_en;
                        overflow_d = 1'b0;
                        state_d    = cds_en ? RST_LVL : SIG_LVL;
                    end
                end
                RST_LVL: begin
                    if (sample_valid) begin
                        rst_reg_d = sample_data;
                        state_d   = SIG_LVL;
                    end
                end
                SIG_LVL: begin
                    if (sample_valid) begin
                        push = 1'b1;
                        if (last_pixel) begin
                            state_d      = IDLE;
                            row_d        = '0;
                            col_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = cds_mode_q ? RST_LVL : SIG_LVL;
                            if (col_q == LAST_COL) begin
                                col_d = '0;
                                row_d = row_q + ROW_BITS'(1);
                            end else begin
                                col_d = col_q + COL_BITS'(1);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Dropped results still advance the raster address above.
            if (push && fifo_full && !pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cds_mode_q   <= 1'b0;
            rst_reg_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cds_mode_q   <= cds_mode_d;
            rst_reg_q    <= rst_reg_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign pop        = !fifo_empty && out_ready;
    assign fifo_wdata = {result, row_q, col_q};

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (fifo_wdata),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign {out_data, out_row, out_col} = fifo_rdata;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_frame_capture.sv
// tb/tb_pixel_frame_capture.sv - directed self-checking bench for pixel_frame_capture
module tb_pixel_frame_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        abort;
    logic        cds_en;
    logic        sample_valid;
    logic [9:0]  sample_data;
    logic        out_ready;
    logic        out_valid;
    logic [9:0]  out_data;
    logic [2:0]  out_row;
    logic [3:0]  out_col;
    logic        busy;
    logic        frame_done;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    int          fd_cnt = 0;
    logic [16:0] exp_q[$];

    pixel_frame_capture dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .abort        (abort),
        .cds_en       (cds_en),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .busy         (busy),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven for the coming edge when this samples the handshake.
    task automatic monitor();
        if (out_valid && out_ready) begin
            check("exp_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("out", 32'({out_data, out_row, out_col}), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (frame_done) fd_cnt++;
    endtask

    task automatic tick();
        monitor();
        @(negedge clk);
    endtask

    task automatic expect_pix(input int v, input int idx);
        exp_q.push_back({10'(v), 3'(idx / 16), 4'(idx % 16)});
    endtask

    task automatic start_frame(input logic cds);
        frame_start = 1'b1;
        cds_en      = cds;
        tick();
        frame_start = 1'b0;
        cds_en      = 1'b0;
    endtask

    task automatic drain(input int n);
        sample_valid = 1'b0;
        out_ready    = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        reset_n = 1'b0; frame_start = 1'b0; abort = 1'b0; cds_en = 1'b0;
        sample_valid = 1'b0; sample_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_outs", 32'({out_data, out_row, out_col}), 32'd0);
        reset_n = 1'b1;
        tick();

        // Samples while idle are ignored.
        sample_valid = 1'b1; sample_data = 10'h3FF;
        repeat (2) tick();
        sample_valid = 1'b0;
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Full non-CDS frame at 0x155 with constant readiness.
        out_ready = 1'b1;
        fd_cnt = 0;
        start_frame(1'b0);
        check("f1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 112; i++) begin
            sample_valid = 1'b1; sample_data = 10'h155;
            expect_pix(10'h155, i);
            tick();
        end
        sample_valid = 1'b0;
        check("f1_done_pulse", 32'(frame_done), 32'd1);
        check("f1_idle", 32'(busy), 32'd0);
        tick();
        check("f1_done_low", 32'(frame_done), 32'd0);
        drain(4);
        check("f1_done_cnt", 32'(fd_cnt), 32'd1);
        check("f1_drained", 32'(exp_q.size()), 32'd0);

        // CDS pairs; cds_en dropped after the start must not change the mode.
        start_frame(1'b1);
        sample_valid = 1'b1;
        sample_data = 10'd800; tick();
        sample_data = 10'd300; expect_pix(500, 0); tick();
        sample_data = 10'd200; tick();
        sample_data = 10'd350; expect_pix(0, 1); tick();
        sample_data = 10'd1000; tick();
        sample_data = 10'd1; expect_pix(999, 2); tick();
        sample_valid = 1'b0;
        check("cds_busy", 32'(busy), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("cds_abort_busy", 32'(busy), 32'd0);
        drain(4);
        check("cds_drained", 32'(exp_q.size()), 32'd0);

        // Full FIFO with a pop and push in the same cycle must not overflow.
        start_frame(1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1; sample_data = 10'(i + 1);
            expect_pix(i + 1, i);
            tick();
        end
        check("sim_pre_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1; sample_data = 10'd5; expect_pix(5, 4);
        tick();
        out_ready = 1'b0;
        check("sim_no_ovf", 32'(overflow), 32'd0);
        check("sim_valid", 32'(out_valid), 32'd1);
        sample_data = 10'd6;
        tick();
        check("sim_still_full", 32'(overflow), 32'd1);
        sample_valid = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_keeps_ovf", 32'(overflow), 32'd1);
        drain(6);
        check("sim_drained", 32'(exp_q.size()), 32'd0);

        // Six results with no readiness: four buffered, overflow on the fifth.
        out_ready = 1'b0;
        start_frame(1'b0);
        check("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 6; i++) begin
            sample_valid = 1'b1; sample_data = 10'(16 + i);
            if (i < 4) expect_pix(16 + i, i);
            tick();
            if (i == 3) check("ovf_after4", 32'(overflow), 32'd0);
            if (i == 4) check("ovf_after5", 32'(overflow), 32'd1);
        end
        sample_valid = 1'b0;
        drain(6);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Abort while pixel (3,5) is presented, then restart at (0,0).
        fd_cnt = 0;
        out_ready = 1'b1;
        start_frame(1'b0);
        for (int i = 0; i < 53; i++) begin
            sample_valid = 1'b1; sample_data = 10'(i);
            expect_pix(i, i);
            tick();
        end
        sample_data = 10'd53; abort = 1'b1; frame_start = 1'b1;
        tick();
        abort = 1'b0; frame_start = 1'b0; sample_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        drain(4);
        check("abort_no_done", 32'(fd_cnt), 32'd0);
        check("abort_drained", 32'(exp_q.size()), 32'd0);
        start_frame(1'b0);
        sample_valid = 1'b1; sample_data = 10'h2A; expect_pix(10'h2A, 0);
        tick();
        drain(3);
        check("restart_addr", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-frame with two entries buffered.
        out_ready = 1'b0;
        sample_valid = 1'b1; sample_data = 10'd7; tick();
        sample_data = 10'd8; tick();
        sample_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("rel_valid", 32'(out_valid), 32'd0);
        check("rel_done", 32'(frame_done), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
